// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one adder_wrapper among NREQ requesters and
// routes each result back to its owner. Optional watchdog: ADDER_ARB_TIMEOUT_EN.
module adder_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned IDW     = 2,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_in1,
    input  logic [NREQ*DWIDTH-1:0] req_in2,
    output logic [NREQ-1:0]        req_ready,
    output logic                   rsp_valid,
    output logic [IDW-1:0]         rsp_id,
    output logic [DWIDTH-1:0]      rsp_sum,
    output logic                   rsp_carry,
    output logic [DWIDTH-1:0]      add_in1,
    output logic [DWIDTH-1:0]      add_in2,
    output logic                   add_ivalid,
    input  logic [DWIDTH-1:0]      add_sum,
    input  logic                   add_carry,
    input  logic                   add_ovalid,
    input  logic                   add_busy,
    output logic                   err
);

    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    // Round-robin pointer and issue registers
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [DWIDTH-1:0] add_in1_q, add_in2_q;
    logic              add_ivalid_q;

    // Owner-ID FIFO
    logic [IDW-1:0] id_mem_q [MAX_OUT];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    // Response and error registers
    logic              rsp_valid_q;
    logic [IDW-1:0]    rsp_id_q;
    logic [DWIDTH-1:0] rsp_sum_q;
    logic              rsp_carry_q;
    logic              err_q, err_d;

    // Arbitration results
    logic              can_issue;
    logic              found;
    logic              grant;
    logic [IDW-1:0]    win;
    logic [NREQ-1:0]   win_oh;
    logic [DWIDTH-1:0] sel_in1, sel_in2;

    logic push, pop, spurious;
    logic flush;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Search ptr..NREQ-1 first, then wrap to 0..ptr-1.
    always_comb begin
        can_issue = !rst && !add_busy && !add_ivalid_q && (count_q < CW'(MAX_OUT));
        found     = 1'b0;
        win       = '0;
        win_oh    = '0;
        sel_in1   = '0;
        sel_in2   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i] && (IDW'(i) >= ptr_q)) begin
                found     = 1'b1;
                win       = IDW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
                sel_in1   = req_in1[i*DWIDTH +: DWIDTH];
                sel_in2   = req_in2[i*DWIDTH +: DWIDTH];
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                win       = IDW'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
                sel_in1   = req_in1[i*DWIDTH +: DWIDTH];
                sel_in2   = req_in2[i*DWIDTH +: DWIDTH];
            end
        end
        grant     = can_issue && found;
        req_ready = grant ? win_oh : '0;
        ptr_d     = ptr_q;
        if (grant) begin
            ptr_d = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        end
    end

    assign push     = grant;
    assign pop      = add_ovalid && (count_q != '0);
    assign spurious = add_ovalid && (count_q == '0);

`ifdef ADDER_ARB_TIMEOUT_EN
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q, wd_d;

    // Counts only cycles that are waiting on an outstanding result.
    always_comb begin
        flush = 1'b0;
        wd_d  = wd_q;
        if (add_ovalid || (count_q == '0)) begin
            wd_d = '0;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
            flush = 1'b1;
            wd_d  = '0;
        end else begin
            wd_d = wd_q + WW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign flush          = 1'b0;
`endif

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A flush keeps only an entry pushed in the same cycle.
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = push ? CW'(1) : '0;
        end
        err_d = spurious || flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            add_in1_q    <= '0;
            add_in2_q    <= '0;
            add_ivalid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_sum_q    <= '0;
            rsp_carry_q  <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < int'(MAX_OUT); i++) begin
                id_mem_q[i] <= '0;
            end
        end else begin
            ptr_q        <= ptr_d;
            add_ivalid_q <= grant;
            if (grant) begin
                add_in1_q <= sel_in1;
                add_in2_q <= sel_in2;
            end
            if (push) begin
                id_mem_q[wr_ptr_q] <= win;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rsp_valid_q <= pop;
            if (pop) begin
                rsp_id_q    <= id_mem_q[rd_ptr_q];
                rsp_sum_q   <= add_sum;
                rsp_carry_q <= add_carry;
            end
            err_q <= err_d;
        end
    end

    assign add_in1    = add_in1_q;
    assign add_in2    = add_in2_q;
    assign add_ivalid = add_ivalid_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_carry  = rsp_carry_q;
    assign err        = err_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: per-cycle vector table for round-robin issue,
// hand sequences for carry, outstanding limit, busy stall, spurious result, watchdog.
module tb_adder_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned DWIDTH = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_in1, req_in2;
    logic [NREQ-1:0]        req_ready;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [7:0]             rsp_sum;
    logic                   rsp_carry;
    logic [7:0]             add_in1, add_in2;
    logic                   add_ivalid;
    logic [7:0]             add_sum;
    logic                   add_carry;
    logic                   add_ovalid;
    logic                   add_busy;
    logic                   err;

    always #5 clk = ~clk;

    adder_arbiter #(
        .NREQ(4), .DWIDTH(8), .IDW(2), .MAX_OUT(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_in1(req_in1), .req_in2(req_in2), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
        .add_in1(add_in1), .add_in2(add_in2), .add_ivalid(add_ivalid),
        .add_sum(add_sum), .add_carry(add_carry), .add_ovalid(add_ovalid),
        .add_busy(add_busy), .err(err)
    );

    // Pipelined adder model, 2-cycle latency, plus a manual result injector.
    logic       auto_en;
    logic       v1, v2;
    logic [8:0] p1, p2;
    logic       man_ov;
    logic [7:0] man_sum;
    logic       man_carry;

    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            p1 <= '0;
            p2 <= '0;
        end else begin
            v1 <= add_ivalid && auto_en;
            p1 <= {1'b0, add_in1} + {1'b0, add_in2};
            v2 <= v1;
            p2 <= p1;
        end
    end

    assign add_ovalid = v2 | man_ov;
    assign add_sum    = v2 ? p2[7:0] : man_sum;
    assign add_carry  = v2 ? p2[8] : man_carry;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rdy;
        logic       iv;
        logic [7:0] in1;
        logic       ro;
        logic [1:0] id;
        logic [7:0] sum;
    } vec_t;

    vec_t tbl [13];
    logic [1:0] drain_ids [4];

    initial begin
        int n;
        int issues;
        int bad;
        int err_n;
        int err_at;

        // cycle: req_valid, req_ready, add_ivalid, add_in1, rsp_valid, rsp_id, rsp_sum
        tbl[0]  = '{4'hF, 4'b0001, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[1]  = '{4'hF, 4'b0000, 1'b1, 8'h01, 1'b0, 2'd0, 8'h00};
        tbl[2]  = '{4'hF, 4'b0010, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[3]  = '{4'hF, 4'b0000, 1'b1, 8'h02, 1'b0, 2'd0, 8'h00};
        tbl[4]  = '{4'hF, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd0, 8'h11};
        tbl[5]  = '{4'hF, 4'b0000, 1'b1, 8'h03, 1'b0, 2'd0, 8'h00};
        tbl[6]  = '{4'hF, 4'b1000, 1'b0, 8'h00, 1'b1, 2'd1, 8'h12};
        tbl[7]  = '{4'hF, 4'b0000, 1'b1, 8'h04, 1'b0, 2'd0, 8'h00};
        tbl[8]  = '{4'hF, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd2, 8'h13};
        tbl[9]  = '{4'h0, 4'b0000, 1'b1, 8'h01, 1'b0, 2'd0, 8'h00};
        tbl[10] = '{4'h0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd3, 8'h14};
        tbl[11] = '{4'h0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 8'h00};
        tbl[12] = '{4'h0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0, 8'h11};
        drain_ids[0] = 2'd0;
        drain_ids[1] = 2'd1;
        drain_ids[2] = 2'd2;
        drain_ids[3] = 2'd3;

        rst       = 1'b1;
        req_valid = 4'hF;
        add_busy  = 1'b0;
        auto_en   = 1'b1;
        man_ov    = 1'b0;
        man_sum   = '0;
        man_carry = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_in1[i*8 +: 8] = 8'(i + 1);
            req_in2[i*8 +: 8] = 8'h10;
        end

        // Reset with every request pending
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_ivalid", 32'(add_ivalid), 32'h0);
        chk("reset_in1", 32'(add_in1), 32'h0);
        chk("reset_in2", 32'(add_in2), 32'h0);
        chk("reset_rsp", 32'({rsp_valid, rsp_id, rsp_sum, rsp_carry}), 32'h0);
        chk("reset_err", 32'(err), 32'h0);

        // Round-robin with pipelined adder, first row is the first cycle after release
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            rst       = 1'b0;
            req_valid = tbl[c].rv;
            #1;
            chk($sformatf("rr_ready[%0d]", c), 32'(req_ready), 32'(tbl[c].rdy));
            chk($sformatf("rr_ivalid[%0d]", c), 32'(add_ivalid), 32'(tbl[c].iv));
            if (tbl[c].iv) begin
                chk($sformatf("rr_in1[%0d]", c), 32'(add_in1), 32'(tbl[c].in1));
                chk($sformatf("rr_in2[%0d]", c), 32'(add_in2), 32'h10);
            end
            chk($sformatf("rr_rsp_valid[%0d]", c), 32'(rsp_valid), 32'(tbl[c].ro));
            if (tbl[c].ro) begin
                chk($sformatf("rr_rsp_id[%0d]", c), 32'(rsp_id), 32'(tbl[c].id));
                chk($sformatf("rr_rsp_sum[%0d]", c), 32'(rsp_sum), 32'(tbl[c].sum));
                chk($sformatf("rr_rsp_carry[%0d]", c), 32'(rsp_carry), 32'h0);
            end
        end

        // Carry path: requester 2 adds 0xFF + 0x01
        @(negedge clk);
        req_in1[2*8 +: 8] = 8'hFF;
        req_in2[2*8 +: 8] = 8'h01;
        req_valid = 4'b0100;
        #1;
        chk("carry_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        chk("carry_ivalid", 32'(add_ivalid), 32'h1);
        chk("carry_operands", 32'({add_in1, add_in2}), 32'hFF01);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                n++;
                chk("carry_rsp", 32'({rsp_id, rsp_sum, rsp_carry}), 32'({2'd2, 8'h00, 1'b1}));
            end
        end
        chk("carry_rsp_count", 32'(n), 32'd1);

        // Outstanding limit: results withheld, ptr starts at 3
        @(negedge clk);
        auto_en = 1'b0;
        req_in1[2*8 +: 8] = 8'h03;
        req_in2[2*8 +: 8] = 8'h10;
        issues = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
            if (add_ivalid) issues++;
        end
        chk("limit_issues", 32'(issues), 32'd4);
        chk("limit_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        man_ov  = 1'b1;
        man_sum = 8'h55;
        #1;
        @(negedge clk);
        man_ov = 1'b0;
        #1;
        chk("limit_rsp", 32'({rsp_valid, rsp_id, rsp_sum}), 32'({1'b1, 2'd3, 8'h55}));
        chk("limit_regrant", 32'(req_ready), 32'b1000);
        issues = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (add_ivalid) issues++;
        end
        chk("limit_one_more", 32'(issues), 32'd1);

        // Drain in issue order: 0,1,2 then the re-issued 3
        req_valid = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            man_ov  = 1'b1;
            man_sum = 8'(k + 32);
            #1;
            @(negedge clk);
            man_ov = 1'b0;
            #1;
            chk($sformatf("drain_rsp[%0d]", k), 32'({rsp_valid, rsp_id, rsp_sum}),
                32'({1'b1, drain_ids[k], 8'(k + 32)}));
        end

        // Busy stall for 8 cycles, then issue as soon as busy drops
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            add_busy  = 1'b1;
            req_valid = 4'b0001;
            #1;
            if (req_ready != 4'h0 || add_ivalid) bad++;
        end
        chk("busy_no_issue", 32'(bad), 32'd0);
        @(negedge clk);
        add_busy = 1'b0;
        auto_en  = 1'b1;
        #1;
        chk("busy_release_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        chk("busy_release_ivalid", 32'(add_ivalid), 32'h1);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                n++;
                chk("busy_rsp", 32'({rsp_id, rsp_sum, rsp_carry}), 32'({2'd0, 8'h11, 1'b0}));
            end
        end
        chk("busy_rsp_count", 32'(n), 32'd1);

        // Spurious result with an empty FIFO
        @(negedge clk);
        man_ov  = 1'b1;
        man_sum = 8'h77;
        #1;
        @(negedge clk);
        man_ov = 1'b0;
        #1;
        chk("spurious_err", 32'(err), 32'h1);
        chk("spurious_no_rsp", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("spurious_err_one_cycle", 32'(err), 32'h0);

`ifdef ADDER_ARB_TIMEOUT_EN
        // One issue with no result: watchdog flushes near cycle 64
        @(negedge clk);
        auto_en   = 1'b0;
        req_valid = 4'b0001;
        #1;
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        err_n  = 0;
        err_at = 0;
        for (int k = 2; k < 90; k++) begin
            @(negedge clk);
            #1;
            if (err) begin
                err_n++;
                err_at = k;
            end
        end
        chk("timeout_err_count", 32'(err_n), 32'd1);
        chk("timeout_err_window", 32'(err_at >= 63 && err_at <= 66), 32'h1);
        @(negedge clk);
        man_ov = 1'b1;
        #1;
        @(negedge clk);
        man_ov = 1'b0;
        #1;
        chk("timeout_flushed", 32'({err, rsp_valid}), 32'b10);
`else
        err_n  = 0;
        err_at = 0;
        chk("idle_err", 32'(err + 1'(err_n + err_at)), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one `adder_wrapper` instance (any `TYP`) among `NREQ` requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues them to the adder one at a time. It tracks the owner of every in-flight operation in an ID FIFO and routes each adder result back to its owner on a shared response bus tagged with the requester ID. It sits between client logic and the adder wrapper.

## Interface
- `NREQ`, 4, number of requesters (2..16)
- `DWIDTH`, 8, operand width; must match the adder instance
- `IDW`, 2, requester ID width; equals $clog2(NREQ)
- `MAX_OUT`, 4, maximum in-flight operations; ID FIFO depth (power of 2, ≥1)
- `TIMEOUT`, 64, watchdog limit in cycles (used only with the macro)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  NREQ  requester i has an operand pair
- `req_in1`  in  NREQ*DWIDTH  operand 1, requester i at bits [i*DWIDTH +: DWIDTH]
- `req_in2`  in  NREQ*DWIDTH  operand 2, same packing
- `req_ready`  out  NREQ  one-hot grant; transfer when valid&ready
- `rsp_valid`  out  1  one-cycle result pulse
- `rsp_id`  out  IDW  owner of the result
- `rsp_sum`  out  DWIDTH  result sum
- `rsp_carry`  out  1  result carry
- `add_in1`, `add_in2`  out  DWIDTH  to adder `in1`/`in2`
- `add_ivalid`  out  1  to adder `ivalid`
- `add_sum`  in  DWIDTH  from adder `Sum`
- `add_carry`  in  1  from adder `Carry`
- `add_ovalid`  in  1  from adder `ovalid`
- `add_busy`  in  1  from adder `busy`
- `err`  out  1  one-cycle error pulse (spurious result or timeout)

## Operation
- Issue window: `can_issue = !add_busy && !add_ivalid && count < MAX_OUT`. `count` is the ID FIFO occupancy.
- When `can_issue` is high, the arbiter grants the first requester with `req_valid` set, searching from `ptr` upward with wrap. `req_ready` is combinational and is zero when `can_issue` is low or no request is present. Only one grant per cycle.
- On transfer from requester w:
  - the winner's operands are registered into `add_in1`/`add_in2`, and `add_ivalid` pulses for exactly one cycle;
  - w is pushed to the ID FIFO;
  - `ptr` ← (w+1) mod NREQ.
- `add_in1`/`add_in2` hold their values until the next issue.
- On `add_ovalid`:
  - the FIFO head is popped;
  - `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_carry` are registered and presented the next cycle.
- Results return in issue order. The adder preserves order for all TYP values.
- Push and pop in the same cycle leave `count` unchanged; the FIFO pointers wrap modulo MAX_OUT.
- `add_ovalid` with `count==0`: no pop, no `rsp_valid`, and `err` pulses.
- Requesters must hold `req_valid` and operands stable until ready. A requester that drops `req_valid` before its grant loses nothing.

## Timing
- Reset values: `req_ready`=0 (because `add_ivalid` and `count` are 0, ready may rise in the first cycle after reset), `add_ivalid`=0, `add_in1`/`add_in2`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_carry`=0, `err`=0, `ptr`=0, `count`=0, FIFO pointers 0.
- Transfer in cycle T → `add_ivalid` high in T+1 → no grant in T+1.
- Adder `ovalid` in cycle R → `rsp_valid` high in R+1.
- Throughput with a pipelined adder (`busy` low): one issue every 2 cycles.
- With a sequential/parallel adder, issue resumes the cycle after `add_busy` falls.
- Reset mid-operation clears all state; in-flight results are dropped. The adder shares `rst`, so no late `add_ovalid` is expected.

## Configuration
- `ADDER_ARB_TIMEOUT_EN` defined: a watchdog counts cycles while `count>0` and `add_ovalid` is low, and resets on any `add_ovalid`. When it reaches `TIMEOUT`:
  - the ID FIFO is flushed (`count`←0);
  - `err` pulses once;
  - the counter clears.
- Not defined: no watchdog logic is built; `err` signals spurious results only.

## Test plan
- Reset: assert `rst` 2 cycles with all `req_valid`=1 → during reset all outputs 0 and `req_ready`=0; `req_ready`=0001 in the first cycle after release.
- Round-robin, pipelined adder (`busy`=0, 2-cycle latency), `req_valid`=1111 held, requester i sends in1=i+1, in2=0x10 → grants in order 0,1,2,3,0; responses (id,sum) = (0,0x11),(1,0x12),(2,0x13),(3,0x14) in order, carry 0.
- Carry path: requester 2 sends 0xFF+0x01 → one `rsp_valid` with id=2, sum=0x00, carry=1.
- Outstanding limit, MAX_OUT=4, adder `ovalid` withheld → exactly 4 issues, then `req_ready`=0; one `ovalid` → one response and one further issue.
- Busy stall: sequential adder holds `busy` high for 8 cycles → no `add_ivalid` in that window; next issue occurs the cycle after `busy` falls.
- Spurious/timeout:
  - `add_ovalid` with count=0 → `err` 1-cycle pulse and no `rsp_valid`.
  - With `ADDER_ARB_TIMEOUT_EN`, TIMEOUT=64, one issue and no `ovalid` → `err` pulses in cycle 64 and `count` returns to 0.
